// File: rtl/status_evaluator.sv
// -----------------------------------------------------------------------------
// status_evaluator
//
// Purpose:
//   Collects a batch of 2**N_LOG2 sensor samples and averages them with a
//   truncating shift. The mean is classified into exactly one of three held,
//   one-hot status levels (aceito / comprometido / rejeitado). A downstream
//   observer watches these levels for rising edges. With REARMA=1 every
//   decision is preceded by one all-low cycle, so a repeated class still
//   produces a fresh rising edge.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   amostra_valida in   sample strobe, one sample per high cycle
//   amostra        in   unsigned sample value [WIDTH-1:0]
//   aceito         out  held: last mean in [LIM_INF, LIM_SUP]
//   comprometido   out  held: last mean in a margin band beside the accepted band
//   rejeitado      out  held: last mean outside every band
//   ocupado        out  high during GAP/DECIDE, when samples are ignored
//   pronto         out  one-cycle pulse as a new status becomes visible
// -----------------------------------------------------------------------------
module status_evaluator #(
    parameter int WIDTH   = 8,
    parameter int N_LOG2  = 2,
    parameter int LIM_INF = 40,
    parameter int LIM_SUP = 200,
    parameter int MARGEM  = 20,
    parameter int REARMA  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             amostra_valida,
    input  logic [WIDTH-1:0] amostra,
    output logic             aceito,
    output logic             comprometido,
    output logic             rejeitado,
    output logic             ocupado,
    output logic             pronto
);

    localparam int SW = WIDTH + N_LOG2;

    // Band limits are evaluated one bit wider than the samples, so the
    // subtraction and addition below cannot wrap. Each band end then
    // saturates at 0 or at the largest sample value.
    localparam logic [WIDTH:0] INF_W   = (WIDTH+1)'(LIM_INF);
    localparam logic [WIDTH:0] SUP_W   = (WIDTH+1)'(LIM_SUP);
    localparam logic [WIDTH:0] MARG_W  = (WIDTH+1)'(MARGEM);
    localparam logic [WIDTH:0] MAX_W   = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] LO_BAND = (INF_W > MARG_W) ? (INF_W - MARG_W) : '0;
    localparam logic [WIDTH:0] HI_BAND = ((SUP_W + MARG_W) > MAX_W) ? MAX_W : (SUP_W + MARG_W);

    typedef enum logic [1:0] {
        ACUMULA = 2'd0,
        GAP     = 2'd1,
        DECIDE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_LOG2-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]       sum_q, sum_d;
    logic [SW-1:0]       batch_q, batch_d;
    logic [2:0]          status_q, status_d;    // {aceito, comprometido, rejeitado}
    logic                pronto_q, pronto_d;
    logic                ocupado_q;

    logic [SW-1:0]       sum_ext;
    logic [WIDTH:0]      mean_w;
    logic [2:0]          class_oh;

    assign sum_ext = sum_q + SW'(amostra);
    assign mean_w  = {1'b0, WIDTH'(batch_q >> N_LOG2)};

    // Priority order makes the result one-hot by construction.
    always_comb begin
        class_oh = 3'b001;
        if (mean_w >= INF_W && mean_w <= SUP_W) begin
            class_oh = 3'b100;
        end else if ((mean_w >= LO_BAND && mean_w < INF_W) ||
                     (mean_w > SUP_W && mean_w <= HI_BAND)) begin
            class_oh = 3'b010;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        batch_d  = batch_q;
        status_d = status_q;
        pronto_d = 1'b0;
        case (state_q)
            ACUMULA: begin
                if (amostra_valida) begin
                    if (cnt_q == N_LOG2'((2**N_LOG2) - 1)) begin
                        // Last sample: freeze the batch sum, start the next batch clean.
                        batch_d = sum_ext;
                        sum_d   = '0;
                        cnt_d   = '0;
                        if (REARMA != 0) begin
                            state_d  = GAP;
                            status_d = 3'b000;
                        end else begin
                            state_d  = DECIDE;
                        end
                    end else begin
                        sum_d = sum_ext;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                state_d = DECIDE;
            end
            DECIDE: begin
                state_d  = ACUMULA;
                status_d = class_oh;
                pronto_d = 1'b1;
            end
            default: begin
                state_d = ACUMULA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACUMULA;
            cnt_q     <= '0;
            sum_q     <= '0;
            batch_q   <= '0;
            status_q  <= 3'b000;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            batch_q   <= batch_d;
            status_q  <= status_d;
            pronto_q  <= pronto_d;
            // Registered from the next state so it is high during GAP/DECIDE.
            ocupado_q <= (state_d != ACUMULA);
        end
    end

    assign aceito       = status_q[2];
    assign comprometido = status_q[1];
    assign rejeitado    = status_q[0];
    assign ocupado      = ocupado_q;
    assign pronto       = pronto_q;

endmodule

// File: tb/tb_status_evaluator.sv
module tb_status_evaluator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       valid;
    logic [7:0] smp;

    logic a0, c0, r0, o0, p0;
    logic a1, c1, r1, o1, p1;
    logic a2, c2, r2, o2, p2;

    // dut0: defaults; dut1: REARMA=1; dut2: both band ends saturate.
    status_evaluator u0 (
        .clk(clk), .rst(rst), .amostra_valida(valid), .amostra(smp),
        .aceito(a0), .comprometido(c0), .rejeitado(r0), .ocupado(o0), .pronto(p0)
    );
    status_evaluator #(.REARMA(1)) u1 (
        .clk(clk), .rst(rst), .amostra_valida(valid), .amostra(smp),
        .aceito(a1), .comprometido(c1), .rejeitado(r1), .ocupado(o1), .pronto(p1)
    );
    status_evaluator #(.LIM_INF(10), .LIM_SUP(245), .MARGEM(20)) u2 (
        .clk(clk), .rst(rst), .amostra_valida(valid), .amostra(smp),
        .aceito(a2), .comprometido(c2), .rejeitado(r2), .ocupado(o2), .pronto(p2)
    );

    logic [2:0][2:0] st;
    logic [2:0]      ocu, pr;
    assign st[0] = {a0, c0, r0};
    assign st[1] = {a1, c1, r1};
    assign st[2] = {a2, c2, r2};
    assign ocu   = {o2, o1, o0};
    assign pr    = {p2, p1, p0};

    // Reference model parameters per instance
    int P_RE [3] = '{0, 1, 0};
    int P_INF[3] = '{40, 40, 10};
    int P_SUP[3] = '{200, 200, 245};
    int P_MAR[3] = '{20, 20, 20};

    int         m_cnt[3], m_sum[3], m_busy[3];
    logic [2:0] m_st[3], m_pend[3];
    logic       m_pr[3];

    int  checks = 0, errors = 0, cyc = 0;
    int  lastp[3], period[3];
    bit  started = 0;
    bit  stream_on = 0, seen_acc = 0;
    int  drops = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Mean classification straight from the band definitions, in plain integers.
    function automatic logic [2:0] classify(int mean, int inf, int sup, int mar);
        int lo, hi;
        lo = inf - mar; if (lo < 0) lo = 0;
        hi = sup + mar; if (hi > 255) hi = 255;
        if (mean >= inf && mean <= sup) return 3'b100;
        if ((mean >= lo && mean < inf) || (mean > sup && mean <= hi)) return 3'b010;
        return 3'b001;
    endfunction

    // Reference model steps on every edge; outputs are compared 1 time unit later.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_sum[i] = 0; m_busy[i] = 0;
                m_st[i] = 3'b000; m_pr[i] = 1'b0;
            end else begin
                m_pr[i] = 1'b0;
                if (m_busy[i] > 0) begin
                    m_busy[i]--;
                    if (m_busy[i] == 0) begin
                        m_st[i] = m_pend[i];
                        m_pr[i] = 1'b1;
                    end
                end else if (valid) begin
                    m_sum[i] += int'(smp);
                    m_cnt[i]++;
                    if (m_cnt[i] == 4) begin
                        m_pend[i] = classify(m_sum[i] / 4, P_INF[i], P_SUP[i], P_MAR[i]);
                        m_sum[i] = 0;
                        m_cnt[i] = 0;
                        if (P_RE[i] != 0) begin
                            m_busy[i] = 2;
                            m_st[i] = 3'b000;
                        end else begin
                            m_busy[i] = 1;
                        end
                    end
                end
            end
        end
        if (rst) started = 1;
        #1;
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("status_u%0d", i), int'(st[i]), int'(m_st[i]));
                chk($sformatf("ocupado_u%0d", i), int'(ocu[i]), (m_busy[i] > 0) ? 1 : 0);
                chk($sformatf("pronto_u%0d", i), int'(pr[i]), int'(m_pr[i]));
                chk($sformatf("onehot_u%0d", i), ($countones(st[i]) <= 1) ? 1 : 0, 1);
                if (pr[i] === 1'b1) begin
                    period[i] = cyc - lastp[i];
                    lastp[i]  = cyc;
                end
            end
            if (stream_on) begin
                if (seen_acc && st[0][2] !== 1'b1) drops++;
                if (pr[0] === 1'b1 && st[0][2] === 1'b1) seen_acc = 1;
            end
        end
    end

    typedef struct {
        int         s[4];
        logic [2:0] exp0;   // default thresholds (u0 and u1)
        logic [2:0] exp2;   // LIM_INF=10, LIM_SUP=245
    } vec_t;

    vec_t vecs[12];

    task automatic apply_batch(input int s0, input int s1, input int s2, input int s3);
        int s[4];
        s = '{s0, s1, s2, s3};
        for (int j = 0; j < 4; j++) begin
            @(negedge clk); valid = 1'b1; smp = 8'(s[j]);
        end
        @(negedge clk); valid = 1'b0; smp = 8'd0;
        repeat (2) @(negedge clk);
    endtask

    int edge_vals[16] = '{0, 19, 20, 38, 39, 40, 41, 199, 200, 201, 219, 220, 221, 225, 245, 255};

    initial begin
        vecs[0]  = '{s: '{100, 100, 100, 100}, exp0: 3'b100, exp2: 3'b100};
        vecs[1]  = '{s: '{30, 30, 30, 30},     exp0: 3'b010, exp2: 3'b100};
        vecs[2]  = '{s: '{250, 250, 250, 250}, exp0: 3'b001, exp2: 3'b010};
        vecs[3]  = '{s: '{39, 40, 41, 40},     exp0: 3'b100, exp2: 3'b100};
        vecs[4]  = '{s: '{38, 39, 39, 39},     exp0: 3'b010, exp2: 3'b100};
        vecs[5]  = '{s: '{221, 221, 221, 221}, exp0: 3'b001, exp2: 3'b100};
        vecs[6]  = '{s: '{220, 220, 220, 220}, exp0: 3'b010, exp2: 3'b100};
        vecs[7]  = '{s: '{19, 20, 20, 20},     exp0: 3'b001, exp2: 3'b100};
        vecs[8]  = '{s: '{0, 0, 0, 0},         exp0: 3'b001, exp2: 3'b010};
        vecs[9]  = '{s: '{255, 255, 255, 255}, exp0: 3'b001, exp2: 3'b010};
        vecs[10] = '{s: '{200, 200, 200, 203}, exp0: 3'b100, exp2: 3'b100};
        vecs[11] = '{s: '{20, 20, 20, 20},     exp0: 3'b010, exp2: 3'b100};

        rst = 1'b1; valid = 1'b0; smp = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", int'({st[0], st[1], st[2], ocu, pr}), 0);

        // Table-driven batches
        for (int v = 0; v < 12; v++) begin
            apply_batch(vecs[v].s[0], vecs[v].s[1], vecs[v].s[2], vecs[v].s[3]);
            chk($sformatf("vec%0d_u0", v), int'(st[0]), int'(vecs[v].exp0));
            chk($sformatf("vec%0d_u1", v), int'(st[1]), int'(vecs[v].exp0));
            chk($sformatf("vec%0d_u2", v), int'(st[2]), int'(vecs[v].exp2));
        end

        // Reset after two samples of a batch: everything clears, no pronto
        @(negedge clk); valid = 1'b1; smp = 8'd100;
        @(negedge clk); valid = 1'b1; smp = 8'd100;
        @(negedge clk); valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midbatch_rst", int'({st[0], st[1], st[2], ocu, pr}), 0);
        repeat (4) @(negedge clk);
        chk("midbatch_nopronto", int'({st[0], st[1], st[2], pr}), 0);

        // Continuous stream of 100: decision period and steady aceito
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; stream_on = 1; valid = 1'b1; smp = 8'd100;
        repeat (40) @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        stream_on = 0;
        chk("stream_period_u0", period[0], 5);
        chk("stream_period_u1", period[1], 6);
        chk("stream_seen_aceito", int'(seen_acc), 1);
        chk("stream_aceito_drops", drops, 0);

        // Randomized traffic with band-edge biased samples and sparse resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 249) == 0);
            valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 0) smp = 8'($urandom_range(0, 255));
            else smp = 8'(edge_vals[$urandom_range(0, 15)]);
        end
        @(negedge clk); rst = 1'b0; valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_evaluator.md
Name: status_evaluator

Overview:
- Producer side of the status-change handshake. Accumulates a batch of sensor samples, averages them and classifies the result into exactly one of three held status levels: aceito, comprometido or rejeitado.
- These levels are the signals the downstream change observer watches for rising edges. Every new decision must therefore present a clean, one-hot level change.
- Sits between the sample source and the observer/reset logic.

Parameters:
- WIDTH, 8, sample and threshold width in bits.
- N_LOG2, 2, log2 of samples per batch (default batch = 4).
- LIM_INF, 40, lower bound of the accepted band (inclusive).
- LIM_SUP, 200, upper bound of the accepted band (inclusive).
- MARGEM, 20, width of the compromised band on each side of the accepted band.
- REARMA, 0, when 1 all status outputs drop low for one cycle before every decision, so a repeated class still produces a rising edge.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- amostra_valida  input  1  sample strobe, one sample per high cycle.
- amostra  input  WIDTH  unsigned sample value.
- aceito  output  1  held level: last batch mean within [LIM_INF, LIM_SUP].
- comprometido  output  1  held level: last batch mean within a margin band.
- rejeitado  output  1  held level: last batch mean outside all bands.
- ocupado  output  1  high while samples are being ignored (DECIDE/GAP).
- pronto  output  1  one-cycle pulse coincident with the new status becoming visible.

Behaviour:
- Reset (sampled at clk edge with rst=1):
  - state=ACUMULA, sample count=0, sum=0.
  - aceito=comprometido=rejeitado=0, ocupado=0, pronto=0.
  - Before the first decision all three status outputs are 0.
- Sum register:
  - Width is WIDTH+N_LOG2 and can never overflow.
  - mean = sum >> N_LOG2, truncating.
- ACUMULA state:
  - Each cycle with amostra_valida=1 adds amostra to sum and increments the count.
  - On the edge that captures sample number 2^N_LOG2, go to DECIDE if REARMA=0, else GAP.
  - Count and sum clear at the same edge.
- GAP state (REARMA=1 only):
  - One cycle.
  - On entry edge all status outputs clear to 0.
  - Next state is DECIDE.
  - The batch sum is preserved in a separate holding register.
- DECIDE state:
  - One cycle.
  - Classification uses the registered batch sum.
  - The exit edge writes the status one-hot and asserts pronto for exactly the following cycle.
  - Next state is ACUMULA.
- Classification (the lower/upper band ends are saturated):
  - aceito if LIM_INF <= mean <= LIM_SUP.
  - comprometido if max(LIM_INF-MARGEM,0) <= mean < LIM_INF, or LIM_SUP < mean <= min(LIM_SUP+MARGEM, 2^WIDTH-1).
  - rejeitado otherwise.
  - Saturation arithmetic is computed at elaboration width WIDTH+1, so there is no wrap-around.
- Latency:
  - With the last batch sample captured at edge k, status updates at edge k+1 (REARMA=0) or k+2 (REARMA=1).
  - pronto is high during the cycle after that edge.
- One-hot guarantees:
  - Status outputs are never more than one high.
  - On a class change the old level falls and the new rises at the same edge, with no overlap and no glitch; all are registered outputs.
- Repeated class:
  - With REARMA=0, the level stays high and no new rising edge occurs.
  - With REARMA=1, the level is low for exactly one cycle.
- ocupado:
  - Equals 1 exactly in GAP/DECIDE, registered so that it is visible during those cycles.
  - amostra_valida while ocupado=1 is ignored and not counted.
- Back-to-back samples: a continuous valid stream yields one decision every 2^N_LOG2+1 cycles (REARMA=0) or +2 cycles (REARMA=1).
- Reset mid-batch or mid-DECIDE/GAP discards the partial batch and pending decision; no pronto is issued.
- Status levels hold indefinitely between decisions; there is no timeout.

Test Plan:
- Defaults, rst then 4 valid samples of 100 at edges k-3..k: aceito=1 from edge k+1, pronto high one cycle, ocupado high during the DECIDE cycle only.
- Batch 30,30,30,30, then batch 250,250,250,250: comprometido=1, then at the second decision edge comprometido falls and rejeitado rises in the same cycle, never two high.
- Truncation: batch 39,40,41,40 (sum 160, mean 40) gives aceito; batch 38,39,39,39 (sum 155, mean 38) gives comprometido; batch 221x4 gives rejeitado; batch 220x4 gives comprometido.
- REARMA=1, two consecutive batches of 100: aceito low for exactly one cycle between them, pronto after each decision, ocupado high 2 cycles per decision, decision period 6 cycles on a continuous stream.
- Continuous valid=1 stream of 100 with REARMA=0: samples during DECIDE not counted, pronto every 5 cycles, aceito held constantly high after the first decision.
- rst asserted after 2 samples of a batch: all outputs 0 next cycle, no pronto. Saturation with LIM_INF=10, MARGEM=20 and batch 0x4: comprometido=1.
